// File: rtl/clock_pkg.sv
// Shared constants and helpers for the digital clock's time-set path.
package clock_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_SET_HR  = 2'b01,
      ST_SET_MIN = 2'b10
   } set_state_t;

   localparam int unsigned VAL_W               = 8;
   localparam int unsigned HR_LIMIT            = 24;
   localparam int unsigned MIN_LIMIT           = 60;
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;

   // BCD digit pair to binary; out-of-range values collapse to zero
   function automatic logic [VAL_W-1:0] bcd_capture(input logic [3:0] tens,
                                                    input logic [3:0] units,
                                                    input int unsigned limit);
      logic [VAL_W-1:0] v;
      v = VAL_W'(tens) * VAL_W'(10) + VAL_W'(units);
      return (v >= VAL_W'(limit)) ? '0 : v;
   endfunction

   function automatic logic [VAL_W-1:0] wrap_inc(input logic [VAL_W-1:0] v,
                                                 input int unsigned limit);
      return (v == VAL_W'(limit - 1)) ? '0 : v + VAL_W'(1);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and
// one-cycle pulse on the accepted rising edge.
module btn_debounce
   import clock_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic level,
   output logic press
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   // cnt tracks consecutive synchronized samples that disagree with level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt   <= '0;
            level <= sync2;
            press <= sync2;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/time_set_ctrl.sv
// Mode/time-set controller feeding the seconds/minutes/hours counter chain.
// Optional INC auto-repeat is built when AUTOREPEAT_EN is defined.
module time_set_ctrl
   import clock_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef AUTOREPEAT_EN
   ,
   parameter int unsigned REPEAT_DELAY    = 1000,
   parameter int unsigned REPEAT_PERIOD   = 250
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_mode,
   input  logic             btn_inc,
   input  logic             tick_1hz,
   input  logic [VAL_W-1:0] sec_carry,
   input  logic [VAL_W-1:0] min_carry,
   input  logic [3:0]       min_t,
   input  logic [3:0]       min_u,
   input  logic [3:0]       hr_t,
   input  logic [3:0]       hr_u,
   output logic             sec_en,
   output logic [VAL_W-1:0] min_in,
   output logic             min_sel,
   output logic [VAL_W-1:0] hr_in,
   output logic             hr_sel,
   output logic [1:0]       set_state
);

   set_state_t       state;
   logic [VAL_W-1:0] hr_reg;
   logic [VAL_W-1:0] min_reg;
   logic             mode_press;
   logic             mode_level;
   logic             inc_press;
   logic             inc_level;
   logic             inc_step;
   logic             unused_levels;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_mode),
      .level (mode_level),
      .press (mode_press)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_inc),
      .level (inc_level),
      .press (inc_press)
   );

`ifdef AUTOREPEAT_EN
   localparam int unsigned REP_W = $clog2(REPEAT_DELAY + 1);

   logic [REP_W-1:0] rep_cnt;
   logic             rep_qual;
   logic             rep_fire;

   // Held-INC timer: first fire at REPEAT_DELAY, then reload so the gap is REPEAT_PERIOD
   assign rep_qual = (state != ST_RUN) && inc_level && !mode_press;
   assign rep_fire = rep_qual && (rep_cnt == REP_W'(REPEAT_DELAY));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rep_cnt <= '0;
      end else if (!rep_qual) begin
         rep_cnt <= '0;
      end else if (rep_fire) begin
         rep_cnt <= REP_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);
      end else begin
         rep_cnt <= rep_cnt + REP_W'(1);
      end
   end

   assign inc_step      = inc_press | rep_fire;
   assign unused_levels = mode_level;
`else
   assign inc_step      = inc_press;
   assign unused_levels = mode_level ^ inc_level;
`endif

   // Mode sequencing and value editing; MODE wins over a same-cycle INC
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_RUN;
         hr_reg  <= '0;
         min_reg <= '0;
      end else if (mode_press) begin
         case (state)
            ST_RUN: begin
               hr_reg  <= bcd_capture(hr_t, hr_u, HR_LIMIT);
               min_reg <= bcd_capture(min_t, min_u, MIN_LIMIT);
               state   <= ST_SET_HR;
            end
            ST_SET_HR: state <= ST_SET_MIN;
            default:   state <= ST_RUN;
         endcase
      end else if (inc_step) begin
         case (state)
            ST_SET_HR:  hr_reg  <= wrap_inc(hr_reg, HR_LIMIT);
            ST_SET_MIN: min_reg <= wrap_inc(min_reg, MIN_LIMIT);
            default: ;
         endcase
      end
   end

   assign set_state = state;

   // Counter-chain drive: carry chaining in RUN, continuous reload while setting
   always_comb begin
      sec_en  = 1'b0;
      min_sel = 1'b1;
      min_in  = sec_carry;
      hr_sel  = 1'b1;
      hr_in   = min_carry;
      if (state == ST_RUN) begin
         sec_en = tick_1hz & ~mode_press;
      end else begin
         min_sel = 1'b0;
         min_in  = min_reg;
         hr_sel  = 1'b0;
         hr_in   = hr_reg;
      end
   end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: abstract cycle model plus directed button scenarios.
module tb_time_set_ctrl;

   localparam int D = 4;
`ifdef AUTOREPEAT_EN
   localparam int RD = 20;
   localparam int RP = 5;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic       tick_1hz = 1'b0;
   logic [7:0] sec_carry = 8'd0;
   logic [7:0] min_carry = 8'd0;
   logic [3:0] min_t = 4'd0;
   logic [3:0] min_u = 4'd0;
   logic [3:0] hr_t = 4'd0;
   logic [3:0] hr_u = 4'd0;
   logic       sec_en;
   logic [7:0] min_in;
   logic       min_sel;
   logic [7:0] hr_in;
   logic       hr_sel;
   logic [1:0] set_state;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   time_set_ctrl #(
      .DEBOUNCE_CYCLES(D)
`ifdef AUTOREPEAT_EN
      , .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
`endif
   ) dut (
      .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .tick_1hz(tick_1hz), .sec_carry(sec_carry), .min_carry(min_carry),
      .min_t(min_t), .min_u(min_u), .hr_t(hr_t), .hr_u(hr_u),
      .sec_en(sec_en), .min_in(min_in), .min_sel(min_sel),
      .hr_in(hr_in), .hr_sel(hr_sel), .set_state(set_state)
   );

   // Model: mode 0=RUN 1=SET_HR 2=SET_MIN; raw button history, newest first
   int m_state = 0;
   int m_hr = 0;
   int m_min = 0;
   int m_val;
   bit lvl_m = 0, lvl_i = 0, p_m = 0, p_i = 0, m_inc;
   bit hm [0:D+1];
   bit hi [0:D+1];
`ifdef AUTOREPEAT_EN
   int held = 0;
   bit m_qual;
`endif

   // A level flips once D consecutive synchronized samples (raw delayed 2) disagree
   function automatic bit must_flip(input bit h [0:D+1], input bit lvl);
      for (int k = 2; k <= D + 1; k++)
         if (h[k] == lvl) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_state = 0; m_hr = 0; m_min = 0;
         lvl_m = 0; lvl_i = 0; p_m = 0; p_i = 0;
         for (int k = 0; k <= D + 1; k++) begin hm[k] = 0; hi[k] = 0; end
`ifdef AUTOREPEAT_EN
         held = 0;
`endif
      end else begin
         m_inc = p_i;
`ifdef AUTOREPEAT_EN
         m_qual = (m_state != 0) && lvl_i && !p_m;
         if (m_qual && held >= RD && ((held - RD) % RP) == 0) m_inc = 1'b1;
         held = m_qual ? held + 1 : 0;
`endif
         if (p_m) begin
            if (m_state == 0) begin
               m_val = hr_t * 10 + hr_u;
               m_hr  = (m_val >= 24) ? 0 : m_val;
               m_val = min_t * 10 + min_u;
               m_min = (m_val >= 60) ? 0 : m_val;
            end
            m_state = (m_state + 1) % 3;
         end else if (m_inc) begin
            if (m_state == 1) m_hr = (m_hr + 1) % 24;
            if (m_state == 2) m_min = (m_min + 1) % 60;
         end
         for (int k = D + 1; k > 0; k--) begin hm[k] = hm[k-1]; hi[k] = hi[k-1]; end
         hm[0] = btn_mode;
         hi[0] = btn_inc;
         p_m = 0;
         p_i = 0;
         if (must_flip(hm, lvl_m)) begin lvl_m = !lvl_m; p_m = lvl_m; end
         if (must_flip(hi, lvl_i)) begin lvl_i = !lvl_i; p_i = lvl_i; end
      end
   end

   logic [20:0] exp_v, act_v;

   always @(negedge clk) begin
      exp_v = (m_state == 0)
         ? {2'd0, tick_1hz & ~p_m, 1'b1, sec_carry, 1'b1, min_carry}
         : {2'(m_state), 1'b0, 1'b0, 8'(m_min), 1'b0, 8'(m_hr)};
      act_v = {set_state, sec_en, min_sel, min_in, hr_sel, hr_in};
      n_vec++;
      if (act_v !== exp_v) begin
         n_err++;
         $display("FAIL cycle_model t=%0t got %h expected %h", $time, act_v, exp_v);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Raise the chosen buttons and return in the cycle the press pulse is visible
   task automatic press(input bit do_mode, input bit do_inc);
      btn_mode = do_mode;
      btn_inc  = do_inc;
      cyc(2 + D);
   endtask

   task automatic release_all();
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      cyc(D + 4);
   endtask

   task automatic mode_click();
      press(1'b1, 1'b0);
      release_all();
   endtask

   task automatic set_digits(input int h, input int m);
      hr_t  = 4'(h / 10); hr_u  = 4'(h % 10);
      min_t = 4'(m / 10); min_u = 4'(m % 10);
   endtask

   logic [9:0] run_vec [6] = '{10'b1_01_0, 10'b0_01_1, 10'b1_00_0, 10'b1_01_1,
                               10'b0_00_0, 10'b1_00_1};

   initial begin
      #2 rst = 1'b1;
      cyc(2);
      chk("reset_state", set_state, 0);
      chk("reset_min_sel", min_sel, 1);
      chk("reset_hr_sel", hr_sel, 1);
      chk("reset_min_in", min_in, 0);
      chk("reset_hr_in", hr_in, 0);
      chk("reset_sec_en", sec_en, 0);
      rst = 1'b0;
      cyc(2);

      tick_1hz = 1'b1; sec_carry = 8'd1; #1;
      chk("run_sec_en", sec_en, 1);
      chk("run_min_in", min_in, 1);
      min_carry = 8'd1; #1;
      chk("run_hr_in", hr_in, 1);
      cyc(1);
      foreach (run_vec[i]) begin
         tick_1hz  = run_vec[i][3];
         sec_carry = 8'(run_vec[i][1]);
         min_carry = 8'(run_vec[i][0]);
         cyc(1);
      end
      tick_1hz = 1'b0; sec_carry = 8'd0; min_carry = 8'd0;

      btn_mode = 1'b1; btn_inc = 1'b1;
      cyc(D - 1);
      release_all();
      chk("glitch_state", set_state, 0);

      set_digits(23, 59);
      tick_1hz = 1'b1;
      press(1'b1, 1'b0);
      chk("capture_sec_en", sec_en, 0);
      chk("capture_pre_state", set_state, 0);
      cyc(1);
      tick_1hz = 1'b0;
      chk("capture_state", set_state, 1);
      chk("capture_hr", hr_in, 23);
      chk("capture_min", min_in, 59);
      chk("capture_sels", {min_sel, hr_sel}, 0);
      release_all();

      press(1'b0, 1'b1); release_all();
      chk("hr_wrap", hr_in, 0);
      mode_click();
      chk("to_set_min", set_state, 2);
      press(1'b0, 1'b1); release_all();
      chk("min_wrap", min_in, 0);
      mode_click();
      chk("back_run", set_state, 0);
      chk("back_run_sels", {min_sel, hr_sel}, 3);

      set_digits(12, 34);
      mode_click();
      chk("cap12", hr_in, 12);
      press(1'b1, 1'b1); release_all();
      chk("simul_state", set_state, 2);
      chk("simul_hr_kept", hr_in, 12);
      chk("simul_min", min_in, 34);
      mode_click();

      hr_t = 4'd9; hr_u = 4'd9; min_t = 4'd7; min_u = 4'd5;
      mode_click();
      chk("invalid_hr", hr_in, 0);
      chk("invalid_min", min_in, 0);
      mode_click(); mode_click();

      set_digits(5, 10);
      mode_click(); mode_click();
      chk("hold_start", min_in, 10);
      btn_inc = 1'b1;
      cyc(40);
      btn_inc = 1'b0;
      cyc(D + 4);
`ifdef AUTOREPEAT_EN
      chk("hold_inc", min_in, 15);
`else
      chk("hold_inc", min_in, 11);
`endif
      chk("hold_hr", hr_in, 5);

      rst = 1'b1; #1;
      chk("midset_state", set_state, 0);
      chk("midset_sels", {min_sel, hr_sel}, 3);
      chk("midset_ins", {min_in, hr_in}, 0);
      chk("midset_sec_en", sec_en, 0);
      cyc(2);
      rst = 1'b0;
      cyc(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
